// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipe (load-use, redirect, dmem wait, timeout error)
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_redirect,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             err_clr,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             memwb_flush,
   output logic             ctrl_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] LIM = WW'(TIMEOUT - 2);
   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
   state_t           state_q, state_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             hazard, in_err, mem_stall, redir, lu;
   // Hazard priority (ERR > memory stall > redirect > load-use), pipe controls and next state
   always_comb begin
      hazard      = ex_memread && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      in_err      = state_q == ERR;
      mem_stall   = !in_err && !dmem_ready && (state_q == MEM_WAIT || dmem_req);
      redir       = !in_err && !mem_stall && ex_redirect;
      lu          = !in_err && !mem_stall && !ex_redirect && hazard;
      pc_en       = rst_n && !in_err && !mem_stall && !lu;
      ifid_en     = pc_en;
      idex_en     = rst_n && !in_err && !mem_stall;
      exmem_en    = idex_en;
      memwb_en    = rst_n && !in_err;
      ifid_flush  = rst_n && redir;
      idex_flush  = rst_n && (redir || lu);
      memwb_flush = rst_n && mem_stall;
      ctrl_err    = in_err;
      state_d     = in_err ? (err_clr ? RUN : ERR) :
                    mem_stall ? ((state_q == MEM_WAIT && wait_cnt_q == LIM) ? ERR : MEM_WAIT) : RUN;
      wait_cnt_d  = (state_q == MEM_WAIT && mem_stall) ? wait_cnt_q + 1'b1 : '0;
      stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (redir && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end
   // State, watchdog and saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle sequences for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   localparam logic [7:0] O_DEF = 8'hD6, O_LU = 8'h1E, O_RED = 8'hFE, O_MEM = 8'h03, O_OFF = 8'h00;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_memread, ex_redirect, dmem_req, dmem_ready, err_clr;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, ctrl_err;
   logic [3:0] stall_cnt, flush_cnt;
   int checks = 0, failures = 0;
   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, rdr, req, rdy;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[10];

   pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .err_clr(err_clr), .pc_en(pc_en),
      .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .memwb_flush(memwb_flush), .ctrl_err(ctrl_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ov();
      return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_memread = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ctrl", {24'd0, ov()}, {24'd0, O_OFF});
      chk("rst_err", {31'd0, ctrl_err}, 32'd0);
      chk("rst_cnt", {24'd0, stall_cnt, flush_cnt}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_ctrl", {24'd0, ov()}, {24'd0, O_DEF});
   endtask

   task automatic setv(input int i, input logic [4:0] rs1, rs2, rd, input logic u1, u2, mr, rdr, req, rdy,
                       input logic [7:0] exp);
      tbl[i] = '{rs1, rs2, rd, u1, u2, mr, rdr, req, rdy, exp};
   endtask

   initial begin
      idle();
      setv(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_DEF);
      setv(1, 5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_LU);
      setv(2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_DEF);
      setv(3, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_LU);
      setv(4, 5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_DEF);
      setv(5, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_DEF);
      setv(6, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_RED);
      setv(7, 5'd3, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, O_RED);
      setv(8, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_DEF);
      setv(9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);

      do_reset();
      foreach (tbl[i]) begin
         @(negedge clk);
         id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
         id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2; ex_memread = tbl[i].mr;
         ex_redirect = tbl[i].rdr; dmem_req = tbl[i].req; dmem_ready = tbl[i].rdy;
         #1;
         chk($sformatf("vec%0d", i), {24'd0, ov()}, {24'd0, tbl[i].exp});
      end

      do_reset();
      @(negedge clk);
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      #1;
      chk("lu_bubble", {24'd0, ov()}, {24'd0, O_LU});
      @(negedge clk);
      idle();
      #1;
      chk("lu_after", {24'd0, ov()}, {24'd0, O_DEF});
      chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);

      do_reset();
      @(negedge clk);
      ex_redirect = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #1;
      chk("red_lu", {24'd0, ov()}, {24'd0, O_RED});
      @(negedge clk);
      idle();
      #1;
      chk("red_lu_fcnt", {28'd0, flush_cnt}, 32'd1);
      chk("red_lu_scnt", {28'd0, stall_cnt}, 32'd0);

      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
         #1;
         chk($sformatf("mem_frz%0d", k), {24'd0, ov()}, {24'd0, O_MEM});
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      chk("mem_done_red", {24'd0, ov()}, {24'd0, O_RED});
      @(negedge clk);
      idle();
      dmem_ready = 1'b0;
      #1;
      chk("mem_run", {24'd0, ov()}, {24'd0, O_DEF});
      chk("mem_scnt", {28'd0, stall_cnt}, 32'd3);
      chk("mem_fcnt", {28'd0, flush_cnt}, 32'd1);

      do_reset();
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst", {24'd0, ov()}, {24'd0, O_OFF});
      @(negedge clk);
      rst_n = 1'b1; dmem_req = 1'b0;
      #1;
      chk("mid_rst_run", {24'd0, ov()}, {24'd0, O_DEF});

      do_reset();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         dmem_req = 1'b1; dmem_ready = 1'b0;
         #1;
         chk($sformatf("to_frz%0d", k), {23'd0, ctrl_err, ov()}, {24'd0, O_MEM});
      end
      @(negedge clk);
      #1;
      chk("to_err", {23'd0, ctrl_err, ov()}, {23'd0, 1'b1, O_OFF});
      @(negedge clk);
      dmem_req = 1'b0; dmem_ready = 1'b1;
      #1;
      chk("err_sticky", {23'd0, ctrl_err, ov()}, {23'd0, 1'b1, O_OFF});
      @(negedge clk);
      err_clr = 1'b1;
      #1;
      chk("err_clr_cyc", {23'd0, ctrl_err, ov()}, {23'd0, 1'b1, O_OFF});
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      chk("err_cleared", {23'd0, ctrl_err, ov()}, {24'd0, O_DEF});
      chk("err_scnt_sat", {28'd0, stall_cnt}, 32'd15);

      do_reset();
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         ex_memread = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
         #1;
         if (k == 16) chk("sat_s15", {28'd0, stall_cnt}, 32'd15);
      end
      @(negedge clk);
      idle();
      #1;
      chk("sat_s_hold", {28'd0, stall_cnt}, 32'd15);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         ex_redirect = 1'b1;
         #1;
         if (k == 15) chk("sat_f14", {28'd0, flush_cnt}, 32'd14);
      end
      @(negedge clk);
      idle();
      #1;
      chk("sat_f_hold", {28'd0, flush_cnt}, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
